div_ctrl: RTL and testbench
===========================

# div_ctrl

Initiator-side controller for the multi-cycle 32-bit divider in the EX stage. It takes a DIV/DIVU request from EX and drives the divider's start/annul handshake. It stalls the pipeline until the quotient and remainder return, then issues a single-cycle HI/LO write. On a pipeline flush it cancels an in-flight division and guarantees the divider is idle before it accepts another request.

## Interface
- Parameters: none. The datapath is fixed at 32 bits.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high. Shared with the divider.
- ex_div_i  in  1  EX holds a DIV/DIVU instruction
- ex_signed_i  in  1  1 = DIV (signed), 0 = DIVU
- ex_rs_i  in  32  dividend
- ex_rt_i  in  32  divisor
- flush_i  in  1  EX instruction is being flushed (exception or redirect)
- div_start_o  out  1  divider start request
- div_annul_o  out  1  divider cancel request
- div_signed_o  out  1  equals ex_signed_i
- div_op1_o  out  32  equals ex_rs_i
- div_op2_o  out  32  equals ex_rt_i
- div_result_i  in  64  {remainder[63:32], quotient[31:0]}
- div_ready_i  in  1  divider result valid
- stall_o  out  1  stall IF/ID/EX
- hilo_we_o  out  1  HI/LO write enable, one cycle per completed division
- hi_o  out  32  remainder to write into HI
- lo_o  out  32  quotient to write into LO

## Operation
- Request: req = ex_div_i & ~flush_i.
- Operand outputs are combinational pass-throughs. Operands stay stable because EX is stalled.
- States: IDLE, BUSY, DONE, ABORT.
- IDLE
  - div_start_o = req, stall_o = req.
  - req → BUSY. The divider samples operands at this edge.
- BUSY
  - div_start_o = 1, stall_o = 1.
  - div_ready_i = 1 → capture div_result_i[63:32] into the HI register and [31:0] into the LO register, go to DONE.
  - flush_i = 1 (takes priority over ready) → ABORT, nothing captured.
- DONE
  - div_start_o = 0, which releases the divider to free. stall_o = 0. EX advances at the end of this cycle.
  - hilo_we_o = ~flush_i.
  - div_ready_i is ignored; it may still read 1 this cycle.
  - Always → IDLE.
- ABORT
  - div_start_o = 0, div_annul_o = 1 for exactly 2 cycles. This covers the divider's worst-case return to free (zero-divisor path → end → free).
  - stall_o = req during ABORT.
  - → IDLE after the 2nd cycle.
- div_annul_o is 0 outside ABORT.
- Divide by zero: no special handling. The divider returns 0, so HI = LO = 0 is written.
- Sign handling is done entirely in the divider. This block never alters operands or results.
- rst in any state: → IDLE next edge; all outputs 0; captured HI/LO registers cleared to 0. Because the divider shares rst, no annul is needed.

## Timing
- Reset values: div_start_o = 0, div_annul_o = 0, stall_o = 0, hilo_we_o = 0, hi_o = 0, lo_o = 0.
- Nonzero divisor, request first seen in cycle 0:
  - div_start_o high cycles 0–35.
  - div_ready_i first seen in cycle 35.
  - stall_o high cycles 0–35.
  - DONE (hilo_we_o = 1) in cycle 36.
- Zero divisor:
  - div_ready_i first seen in cycle 3.
  - stall_o high cycles 0–3.
  - DONE in cycle 4.
- hilo_we_o is high for exactly one cycle per completed, unflushed division. hi_o/lo_o are valid in that cycle and hold until the next capture.
- Back-to-back divisions: after DONE the block is in IDLE, and a new req starts in the cycle immediately following DONE. The divider is already free by then.
- A flush during ABORT or IDLE has no additional effect.

## Test plan
- DIVU 100 / 7, no flush → stall_o cycles 0–35; cycle 36: hilo_we_o = 1, lo_o = 14, hi_o = 2.
- DIV 0xFFFFFFF9 (−7) / 2 → cycle 36: lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF; DIV 7 / 0xFFFFFFFE → lo_o = 0xFFFFFFFD, hi_o = 1.
- DIVU 5 / 0 → stall_o cycles 0–3; cycle 4: hilo_we_o = 1, hi_o = lo_o = 0.
- flush_i pulsed in cycle 10 of DIVU 100 / 7 → div_annul_o high cycles 11–12, no hilo_we_o ever. Then DIVU 9 / 3 presented in cycle 12 → held stalled, starts in cycle 13, writes lo_o = 3, hi_o = 0 in cycle 49.
- Two consecutive DIVU ops (20 / 6, then 0xFFFFFFFF / 0x10) → writes (hi 2, lo 3) in cycle 36, then (hi 0xF, lo 0x0FFFFFFF) in cycle 73. Exactly two hilo_we_o pulses.
- rst asserted in cycle 15 of a division → all outputs 0 next cycle. A DIVU 8 / 2 presented after rst release completes normally with lo_o = 4, hi_o = 0.

Source files
------------

// File: rtl/div_ctrl_if.sv
// Start/annul handshake and operand/result bus between the EX-stage
// divide controller (master) and the multi-cycle divider (slave).
`timescale 1ns/1ps
interface div_ctrl_if;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_op1_o;
  logic [31:0] div_op2_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;

  modport master (
    output div_start_o,
    output div_annul_o,
    output div_signed_o,
    output div_op1_o,
    output div_op2_o,
    input  div_result_i,
    input  div_ready_i
  );

  modport slave (
    input  div_start_o,
    input  div_annul_o,
    input  div_signed_o,
    input  div_op1_o,
    input  div_op2_o,
    output div_result_i,
    output div_ready_i
  );
endinterface

// File: rtl/div_ctrl.sv
// EX-stage divide controller: starts the divider, stalls the pipe until the
// result returns, issues a one-cycle HI/LO write, and annuls on flush.
`timescale 1ns/1ps
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_i,
  input  logic        ex_signed_i,
  input  logic [31:0] ex_rs_i,
  input  logic [31:0] ex_rt_i,
  input  logic        flush_i,
  div_ctrl_if.master  div,
  output logic        stall_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned DataW = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE,
    ST_ABORT
  } state_e;

  state_e           state_q, state_d;
  logic             abort_last_q, abort_last_d;
  logic [DataW-1:0] hi_q, hi_d;
  logic [DataW-1:0] lo_q, lo_d;

  logic req;
  logic start_c;
  logic annul_c;
  logic stall_c;
  logic we_c;

  assign req = ex_div_i & ~flush_i;

  // Operands are held stable by the stall, so they pass straight through.
  assign div.div_signed_o = ex_signed_i;
  assign div.div_op1_o    = ex_rs_i;
  assign div.div_op2_o    = ex_rt_i;

  always_comb begin
    state_d      = state_q;
    abort_last_d = abort_last_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    start_c      = 1'b0;
    annul_c      = 1'b0;
    stall_c      = 1'b0;
    we_c         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        start_c = req;
        stall_c = req;
        if (req) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        start_c = 1'b1;
        stall_c = 1'b1;
        // Flush wins over a same-cycle ready: the result is discarded.
        if (flush_i) begin
          state_d      = ST_ABORT;
          abort_last_d = 1'b0;
        end else if (div.div_ready_i) begin
          hi_d    = div.div_result_i[63:32];
          lo_d    = div.div_result_i[31:0];
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        we_c    = ~flush_i;
        state_d = ST_IDLE;
      end
      ST_ABORT: begin
        // Two annul cycles cover the divider's slowest path back to free.
        annul_c = 1'b1;
        stall_c = req;
        if (abort_last_q) begin
          state_d      = ST_IDLE;
          abort_last_d = 1'b0;
        end else begin
          abort_last_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rst) begin
      start_c = 1'b0;
      annul_c = 1'b0;
      stall_c = 1'b0;
      we_c    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      abort_last_q <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      abort_last_q <= abort_last_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  assign div.div_start_o = start_c;
  assign div.div_annul_o = annul_c;
  assign stall_o         = stall_c;
  assign hilo_we_o       = we_c;
  assign hi_o            = hi_q;
  assign lo_o            = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: behavioural divider plus cycle-indexed expectations
// derived from the operation's latency and plain arithmetic.
`timescale 1ns/1ps
module tb_div_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        ex_div = 1'b0;
  logic        ex_signed = 1'b0;
  logic [31:0] ex_rs = '0;
  logic [31:0] ex_rt = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        hilo_we;
  logic [31:0] hi;
  logic [31:0] lo;

  div_ctrl_if dif ();

  div_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .ex_div_i    (ex_div),
    .ex_signed_i (ex_signed),
    .ex_rs_i     (ex_rs),
    .ex_rt_i     (ex_rt),
    .flush_i     (flush),
    .div         (dif),
    .stall_o     (stall),
    .hilo_we_o   (hilo_we),
    .hi_o        (hi),
    .lo_o        (lo)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  // {remainder, quotient}; zero divisor yields zero.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Divider: ready from cycle 35 after start (cycle 3 for zero divisor),
  // held until start drops; annul or start release frees it.
  logic        dv_busy;
  int          dv_cyc;
  int          dv_lat;
  logic [63:0] dv_res;
  always @(posedge clk) begin
    if (rst) begin
      dv_busy <= 1'b0;
      dv_cyc  <= 0;
    end else if (!dv_busy) begin
      if (dif.div_start_o && !dif.div_annul_o) begin
        dv_busy <= 1'b1;
        dv_cyc  <= 1;
        dv_lat  <= (dif.div_op2_o == 32'd0) ? 3 : 35;
        dv_res  <= ref_div(dif.div_signed_o, dif.div_op1_o, dif.div_op2_o);
      end
    end else if (!dif.div_start_o || dif.div_annul_o) begin
      dv_busy <= 1'b0;
    end else begin
      dv_cyc <= dv_cyc + 1;
    end
  end
  assign dif.div_ready_i  = dv_busy && (dv_cyc >= dv_lat);
  assign dif.div_result_i = dif.div_ready_i ? dv_res : 64'hBAD0_BAD1_BAD2_BAD3;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic st, input logic an,
                         input logic sl, input logic we);
    chk1({tag, ".start"}, dif.div_start_o, st);
    chk1({tag, ".annul"}, dif.div_annul_o, an);
    chk1({tag, ".stall"}, stall, sl);
    chk1({tag, ".hilo_we"}, hilo_we, we);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles, sometimes with a flushed (hence inert) request.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      flush  = 1'($urandom_range(0, 1));
      ex_div = flush;
      @(negedge clk);
      chk_ctl("idle", 1'b0, 1'b0, 1'b0, 1'b0);
      chk32("idle.hi", hi, exp_hi);
      chk32("idle.lo", lo, exp_lo);
      next_cycle();
    end
    flush  = 1'b0;
    ex_div = 1'b0;
  endtask

  // One division presented in cycle 0. flush_at > 0 flushes in BUSY; flush_done
  // flushes in the DONE cycle; nxt_v presents the next op in the 2nd abort cycle.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, input logic flush_done, input logic nxt_v,
                         input logic nsgn, input logic [31:0] na, input logic [31:0] nb);
    int          lat;
    logic [63:0] res;
    logic        fl;
    lat       = (b == 32'd0) ? 3 : 35;
    res       = ref_div(sgn, a, b);
    ex_div    = 1'b1;
    ex_signed = sgn;
    ex_rs     = a;
    ex_rt     = b;
    flush     = 1'b0;
    for (int c = 0; c <= lat + 1; c++) begin
      if (flush_at > 0 && c == flush_at) begin
        flush = 1'b1;
        @(negedge clk);
        chk_ctl("flush", 1'b1, 1'b0, 1'b1, 1'b0);
        next_cycle();
        fl     = 1'($urandom_range(0, 1));
        flush  = fl;
        ex_div = fl;
        @(negedge clk);
        chk_ctl("abort1", 1'b0, 1'b1, 1'b0, 1'b0);
        chk32("abort1.hi", hi, exp_hi);
        chk32("abort1.lo", lo, exp_lo);
        next_cycle();
        flush  = 1'b0;
        ex_div = nxt_v;
        if (nxt_v) begin
          ex_signed = nsgn;
          ex_rs     = na;
          ex_rt     = nb;
        end
        @(negedge clk);
        chk_ctl("abort2", 1'b0, 1'b1, nxt_v, 1'b0);
        chk32("abort2.lo", lo, exp_lo);
        next_cycle();
        return;
      end
      flush = (c == lat + 1) && flush_done;
      @(negedge clk);
      chk_ctl("div", c <= lat, 1'b0, c <= lat, (c == lat + 1) && !flush_done);
      if (c == 0) begin
        chk32("op1", dif.div_op1_o, a);
        chk32("op2", dif.div_op2_o, b);
        chk1("signed", dif.div_signed_o, sgn);
      end
      if (c == lat + 1) begin
        chk32("hi", hi, res[63:32]);
        chk32("lo", lo, res[31:0]);
      end else begin
        chk32("hold.hi", hi, exp_hi);
        chk32("hold.lo", lo, exp_lo);
      end
      next_cycle();
    end
    exp_hi = res[63:32];
    exp_lo = res[31:0];
    ex_div = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic gen_op(output logic sgn, output logic [31:0] a, output logic [31:0] b);
    sgn = 1'($urandom_range(0, 1));
    a   = $urandom;
    case ($urandom_range(0, 5))
      0:       b = 32'd0;
      1, 2:    b = 32'($urandom_range(1, 16));
      3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
      default: b = $urandom;
    endcase
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
  endtask

  logic        p_sgn, n_sgn;
  logic [31:0] p_a, p_b, n_a, n_b;
  int          fa;
  logic        fd, nv;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk32("reset.hi", hi, 32'd0);
    chk32("reset.lo", lo, 32'd0);
    next_cycle();
    rst = 1'b0;
    idle(1);

    // Directed cases
    run_div(1'b0, 32'd100, 32'd7, -1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(1);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(1);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, -1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(1);
    run_div(1'b0, 32'd5, 32'd0, -1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(1);
    run_div(1'b0, 32'd100, 32'd7, 10, 1'b0, 1'b1, 1'b0, 32'd9, 32'd3);
    run_div(1'b0, 32'd9, 32'd3, -1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(1);
    run_div(1'b0, 32'd20, 32'd6, -1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    run_div(1'b0, 32'hFFFF_FFFF, 32'h10, -1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(2);
    run_div(1'b0, 32'd50, 32'd7, -1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(1);

    // Synchronous reset in cycle 15 of a division
    ex_div = 1'b1; ex_signed = 1'b0; ex_rs = 32'd1000; ex_rt = 32'd3;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      chk_ctl("pre_rst", 1'b1, 1'b0, 1'b1, 1'b0);
      next_cycle();
    end
    rst    = 1'b1;
    ex_div = 1'b0;
    next_cycle();
    rst    = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    chk_ctl("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk32("post_rst.hi", hi, 32'd0);
    chk32("post_rst.lo", lo, 32'd0);
    next_cycle();
    run_div(1'b0, 32'd8, 32'd2, -1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(1);

    // Randomized operations with occasional flushes
    gen_op(p_sgn, p_a, p_b);
    for (int i = 0; i < 24; i++) begin
      gen_op(n_sgn, n_a, n_b);
      fa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (p_b == 32'd0) ? 3 : 35) : -1;
      fd = (fa < 0) && ($urandom_range(0, 5) == 0);
      nv = (fa > 0) && 1'($urandom_range(0, 1));
      run_div(p_sgn, p_a, p_b, fa, fd, nv, n_sgn, n_a, n_b);
      if (!nv && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      p_sgn = n_sgn;
      p_a   = n_a;
      p_b   = n_b;
    end
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
